// File: rtl/lc3_exec_wb.sv
// lc3_exec_wb -- LC-3 execute/writeback stage for operate instructions.
//
// Sits directly downstream of the 8x16 register file. It accepts one decoded
// ADD/AND/NOT/PASSA instruction per handshake and latches both operands on
// the accept edge. It computes the result into a register and writes it back
// through the register-file write port. It also keeps the NZP condition codes
// and a count of retired instructions.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   inValid/inReady   instruction handshake (accept on inValid & inReady)
//   aluk, dr, sr1,    decoded instruction fields
//   sr2, useImm, imm5
//   rdAddrA/rdAddrB   register-file read addresses (pass-through of sr1/sr2)
//   rdDataA/rdDataB   register-file asynchronous read data
//   writeEN, wrAddr,  register-file write port
//   wrData
//   nzp               condition codes {N,Z,P}
//   done              one-cycle pulse while a result is being written
//   retired           number of written-back instructions (wraps)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an instruction; operands latched on accept
// EXEC  | ALU result computed into the write-data register
// WB    | write port active; NZP and retired update on the closing edge

module lc3_exec_wb #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       aluk,
    input  logic [2:0]       dr,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    input  logic             useImm,
    input  logic [4:0]       imm5,
    output logic [2:0]       rdAddrA,
    output logic [2:0]       rdAddrB,
    input  logic [WIDTH-1:0] rdDataA,
    input  logic [WIDTH-1:0] rdDataB,
    output logic             writeEN,
    output logic [2:0]       wrAddr,
    output logic [WIDTH-1:0] wrData,
    output logic [2:0]       nzp,
    output logic             done,
    output logic [CNTW-1:0]  retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_AND   = 2'b01;
    localparam logic [1:0] OP_NOT   = 2'b10;
    localparam logic [1:0] OP_PASSA = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       aluk_q;
    logic [2:0]       dr_q;
    logic             in_ready_q;
    logic             we_q;
    logic             done_q;
    logic [2:0]       wr_addr_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [2:0]       nzp_q;
    logic [CNTW-1:0]  retired_q;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] op_b_sel;
    logic [WIDTH-1:0] alu_res;
    logic [2:0]       nzp_next;

    assign rdAddrA = sr1;
    assign rdAddrB = sr2;

    assign imm_sext = {{(WIDTH-5){imm5[4]}}, imm5};
    assign op_b_sel = useImm ? imm_sext : rdDataB;

    always_comb begin
        alu_res = '0;
        case (aluk_q)
            OP_ADD:   alu_res = op_a + op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_NOT:   alu_res = ~op_a;
            OP_PASSA: alu_res = op_a;
            default:  alu_res = op_a;
        endcase
    end

    // Condition codes are derived from the result being written, so exactly
    // one of N/Z/P is ever set.
    always_comb begin
        nzp_next = 3'b001;
        if (wr_data_q[WIDTH-1]) begin
            nzp_next = 3'b100;
        end else if (wr_data_q == '0) begin
            nzp_next = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_a       <= '0;
            op_b       <= '0;
            aluk_q     <= '0;
            dr_q       <= '0;
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            nzp_q      <= 3'b010;
            retired_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        op_a       <= rdDataA;
                        op_b       <= op_b_sel;
                        aluk_q     <= aluk;
                        dr_q       <= dr;
                        in_ready_q <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Write port outputs are loaded here so they are stable,
                    // register-driven values for the whole WB cycle.
                    wr_data_q <= alu_res;
                    wr_addr_q <= dr_q;
                    we_q      <= 1'b1;
                    done_q    <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    we_q       <= 1'b0;
                    done_q     <= 1'b0;
                    nzp_q      <= nzp_next;
                    retired_q  <= retired_q + {{(CNTW-1){1'b0}}, 1'b1};
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    we_q       <= 1'b0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // The register file samples writeEN on the same edge that applies reset.
    // Masking with rst keeps a write in WB from landing on that edge, so the
    // in-flight instruction is fully discarded.
    assign writeEN = we_q & ~rst;
    assign done    = done_q & ~rst;
    assign inReady = in_ready_q;
    assign wrAddr  = wr_addr_q;
    assign wrData  = wr_data_q;
    assign nzp     = nzp_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_lc3_exec_wb.sv
module tb_lc3_exec_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [1:0]  aluk;
    logic [2:0]  dr, sr1, sr2;
    logic        useImm;
    logic [4:0]  imm5;
    logic        inReady, writeEN, done;
    logic [2:0]  rdAddrA, rdAddrB, wrAddr, nzp;
    logic [15:0] rdDataA, rdDataB, wrData, retired;

    // Narrow-counter instance: same stimulus, used to observe counter wrap
    logic        s_inReady, s_writeEN, s_done;
    logic [2:0]  s_rdAddrA, s_rdAddrB, s_wrAddr, s_nzp;
    logic [15:0] s_wrData;
    logic [2:0]  s_retired;

    always #5 clk = ~clk;

    lc3_exec_wb #(.WIDTH(16), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .aluk(aluk), .dr(dr), .sr1(sr1), .sr2(sr2), .useImm(useImm),
        .imm5(imm5), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .rdDataA(rdDataA), .rdDataB(rdDataB), .writeEN(writeEN),
        .wrAddr(wrAddr), .wrData(wrData), .nzp(nzp), .done(done),
        .retired(retired)
    );

    lc3_exec_wb #(.WIDTH(16), .CNTW(3)) u_dut_small (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(s_inReady),
        .aluk(aluk), .dr(dr), .sr1(sr1), .sr2(sr2), .useImm(useImm),
        .imm5(imm5), .rdAddrA(s_rdAddrA), .rdAddrB(s_rdAddrB),
        .rdDataA(rdDataA), .rdDataB(rdDataB), .writeEN(s_writeEN),
        .wrAddr(s_wrAddr), .wrData(s_wrData), .nzp(s_nzp), .done(s_done),
        .retired(s_retired)
    );

    // Register file model: async read, write on posedge, plus a preload port
    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (writeEN) rf[wrAddr] <= wrData;
    end
    assign rdDataA = rf[rdAddrA];
    assign rdDataB = rf[rdAddrB];

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic [2:0]  nzp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] shadow [8];
    logic [15:0] ret_exp = '0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          pend = 1'b0;
    logic [2:0]  pend_nzp = 3'b010;
    int          wcount = 0;
    bit          b2b_mode = 1'b0;
    bit          have_last = 1'b0;
    time         last_wt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return ~a;
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] cc(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    // Scoreboard consumer: pops on every write, checks NZP/retired next cycle
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            chk("nzp_after_wb", {29'b0, nzp}, {29'b0, pend_nzp});
            chk("retired", {16'b0, retired}, {16'b0, ret_exp});
            chk("retired_small", {29'b0, s_retired}, {29'b0, ret_exp[2:0]});
            chk("inready_after_wb", {31'b0, inReady}, 32'd1);
            pend = 1'b0;
        end
        if (writeEN) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {31'b0, writeEN}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wraddr", {29'b0, wrAddr}, {29'b0, e.addr});
                chk("wrdata", {16'b0, wrData}, {16'b0, e.data});
                chk("done", {31'b0, done}, 32'd1);
                shadow[e.addr] = e.data;
                ret_exp = ret_exp + 16'd1;
                pend_nzp = e.nzp;
                pend = 1'b1;
                wcount++;
                if (b2b_mode && have_last)
                    chk("b2b_spacing", 32'($time - last_wt), 32'd30);
                have_last = 1'b1;
                last_wt = $time;
            end
        end
    end

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        shadow[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic ui, input logic [4:0] im,
                         input bit hold);
        int n = 0;
        logic [15:0] b, r;
        aluk = op; dr = d; sr1 = s1; sr2 = s2; useImm = ui; imm5 = im;
        inValid = 1'b1;
        while (!inReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {31'b0, inReady}, 32'd1);
        b = ui ? {{11{im[4]}}, im} : shadow[s2];
        r = model(op, shadow[s1], b);
        sb.push_back('{addr: d, data: r, nzp: cc(r)});
        @(negedge clk);
        if (!hold) inValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size() + {31'b0, pend}, 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_inready"}, {31'b0, inReady}, 32'd1);
        chk({tag, "_nzp"}, {29'b0, nzp}, 32'd2);
        chk({tag, "_retired"}, {16'b0, retired}, 32'd0);
        chk({tag, "_we"}, {31'b0, writeEN}, 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 8; i++) shadow[i] = 16'h0000;
        rst = 1'b1; inValid = 1'b0; aluk = '0; dr = '0; sr1 = '0; sr2 = '0;
        useImm = 1'b0; imm5 = '0;
        pre_we = 1'b1; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pre_addr = 3'(i);
        end
        pre_we = 1'b0;

        // Reset, then idle
        @(negedge clk); @(negedge clk);
        reset_checks("reset");
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_wraddr", {29'b0, wrAddr}, 32'd0);
        chk("reset_wrdata", {16'b0, wrData}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_we", {31'b0, writeEN}, 32'd0);
        end

        // ADD immediate: 5 + (-3)
        preload(3'd1, 16'h0005);
        issue(2'b00, 3'd2, 3'd1, 3'd0, 1'b1, 5'b11101, 1'b0);
        drain();
        chk("add_imm_rf", {16'b0, rf[2]}, 32'h0002);
        chk("add_imm_nzp", {29'b0, nzp}, 32'd1);
        chk("add_imm_retired", {16'b0, retired}, 32'd1);

        // AND to zero, then NOT negative
        preload(3'd3, 16'h00F0);
        preload(3'd4, 16'h0F0F);
        issue(2'b01, 3'd5, 3'd3, 3'd4, 1'b0, 5'd0, 1'b0);
        drain();
        chk("and_rf", {16'b0, rf[5]}, 32'h0000);
        chk("and_nzp", {29'b0, nzp}, 32'd2);
        issue(2'b10, 3'd6, 3'd3, 3'd0, 1'b0, 5'd0, 1'b0);
        drain();
        chk("not_rf", {16'b0, rf[6]}, 32'hFF0F);
        chk("not_nzp", {29'b0, nzp}, 32'd4);

        // Back-to-back dependent ADDs with inValid held high
        preload(3'd1, 16'h7FFF);
        w0 = wcount;
        have_last = 1'b0;
        b2b_mode = 1'b1;
        for (int i = 0; i < 4; i++)
            issue(2'b00, 3'd1, 3'd1, 3'd0, 1'b1, 5'd1, i != 3);
        drain();
        b2b_mode = 1'b0;
        chk("b2b_writes", 32'(wcount - w0), 32'd4);
        chk("b2b_rf", {16'b0, rf[1]}, 32'h8003);
        chk("b2b_nzp", {29'b0, nzp}, 32'd4);

        // 0xFFFF + 1 wraps to zero; eighth retirement wraps the 3-bit counter
        preload(3'd7, 16'hFFFF);
        issue(2'b00, 3'd0, 3'd7, 3'd0, 1'b1, 5'd1, 1'b0);
        drain();
        chk("wrap_rf", {16'b0, rf[0]}, 32'h0000);
        chk("wrap_nzp", {29'b0, nzp}, 32'd2);
        chk("wrap_retired", {16'b0, retired}, 32'd8);
        chk("wrap_small_cnt", {29'b0, s_retired}, 32'd0);

        // Positive result so reset's effect on nzp is visible
        issue(2'b00, 3'd4, 3'd2, 3'd0, 1'b1, 5'd0, 1'b0);
        drain();
        chk("pos_nzp", {29'b0, nzp}, 32'd1);

        // Reset while in EXEC (dr=5 holds 0x0000)
        aluk = 2'b00; dr = 3'd5; sr1 = 3'd2; useImm = 1'b1; imm5 = 5'd1;
        inValid = 1'b1;
        @(posedge clk); #2;
        inValid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_we", {31'b0, writeEN}, 32'd0);
        @(negedge clk);
        reset_checks("rst_exec");
        rst = 1'b0;
        ret_exp = '0;
        @(negedge clk);
        chk("rst_exec_rf", {16'b0, rf[5]}, 32'h0000);

        issue(2'b00, 3'd4, 3'd2, 3'd0, 1'b1, 5'd0, 1'b0);
        drain();
        chk("pos2_nzp", {29'b0, nzp}, 32'd1);

        // Reset while in WB (dr=6 holds 0xFF0F)
        aluk = 2'b00; dr = 3'd6; sr1 = 3'd2; useImm = 1'b1; imm5 = 5'd1;
        inValid = 1'b1;
        @(posedge clk); #2;
        inValid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wb_we", {31'b0, writeEN}, 32'd0);
        chk("rst_wb_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset_checks("rst_wb");
        rst = 1'b0;
        ret_exp = '0;
        @(negedge clk);
        chk("rst_wb_rf", {16'b0, rf[6]}, 32'hFF0F);

        // Recovery after reset
        issue(2'b00, 3'd1, 3'd2, 3'd0, 1'b1, 5'd3, 1'b0);
        drain();
        chk("recover_rf", {16'b0, rf[1]}, 32'h0005);
        chk("recover_retired", {16'b0, retired}, 32'd1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lc3_exec_wb.md
Name: lc3_exec_wb

Overview:
- Execute/writeback stage directly downstream of the 8x16 register file in the LC-3 datapath.
- Accepts one decoded operate instruction (ADD/AND/NOT/pass) per handshake and drives SR1/SR2 read addresses.
- Captures both operands, computes the 16-bit result, and writes it back through the register file write port (writeEN/wrAddr/wrData).
- Maintains the NZP condition-code register and a retired-instruction counter.

Parameters:
- WIDTH, 16, datapath width; must match the register file data width.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  decoded instruction present on inputs.
- inReady  output  1  stage can accept an instruction this cycle.
- aluk  input  2  operation: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- dr  input  3  destination register.
- sr1  input  3  source register A.
- sr2  input  3  source register B.
- useImm  input  1  1 selects sign-extended imm5 as operand B instead of register sr2.
- imm5  input  5  immediate field.
- rdAddrA  output  3  to register file SR1 port.
- rdAddrB  output  3  to register file SR2 port.
- rdDataA  input  WIDTH  Ra from register file (asynchronous read).
- rdDataB  input  WIDTH  Rb from register file.
- writeEN  output  1  register file write enable.
- wrAddr  output  3  register file write address (DR).
- wrData  output  WIDTH  register file write data (result).
- nzp  output  3  condition codes {N,Z,P}.
- done  output  1  one-cycle pulse when a result is written.
- retired  output  CNTW  count of written-back instructions.

Behaviour:
- Reset values: state IDLE, inReady=1, writeEN=0, wrAddr=0, wrData=0, nzp=3'b010, done=0, retired=0, all internal latches 0.
- rdAddrA=sr1 and rdAddrB=sr2, combinational pass-through at all times. Operands are sampled only on the accept edge.
- FSM states: IDLE, EXEC, WB.
- IDLE: inReady=1. On inValid=1 at a posedge:
  - latch opA=rdDataA.
  - latch opB = useImm ? sign-extend(imm5) : rdDataB.
  - latch aluk and dr; go to EXEC.
  - With inValid=0, remain in IDLE.
- EXEC: inReady=0. Compute result into a register (registered, not combinational to wrData):
  - ADD: opA+opB mod 2^WIDTH, carry discarded.
  - AND: opA&opB.
  - NOT: ~opA.
  - PASSA: opA.
  - Go to WB.
- WB: inReady=0, writeEN=1, wrAddr=latched dr, wrData=result, done=1.
  - At the posedge ending WB: nzp updates to N=result[WIDTH-1], Z=(result==0), P=otherwise (exactly one bit set); retired increments, wrapping all-ones->0; go to IDLE.
- writeEN, wrAddr, wrData and done are driven from state/registers, glitch-free; writeEN and done are high only in WB.
- Latency: accept at edge T; write occurs at edge T+2; inReady high again the cycle after T+2. Throughput is 1 instruction per 3 cycles.
- No read-after-write hazard: the next accept samples the register file no earlier than the edge after the writeback edge.
- inValid is ignored in EXEC and WB; the upstream holds inputs until inReady&inValid.
- rst asserted in any state, including WB: next state IDLE, no write on that edge, nzp=010, retired=0; the in-flight instruction is discarded.
- rst takes priority over a simultaneous accept.
- imm5 sign extension: bit 4 replicated into bits WIDTH-1..5.

Test Plan:
- Reset then idle: rst for 2 cycles -> inReady=1, writeEN=0, nzp=010, retired=0; hold 10 idle cycles -> no writeEN.
- ADD imm: R1 preloaded 0x0005; accept aluk=00, dr=2, sr1=1, useImm=1, imm5=5'b11101 (-3) -> 2 cycles later writeEN=1, wrAddr=2, wrData=0x0002, done=1; next cycle nzp=001, retired=1, inReady=1.
- AND to zero, then NOT negative:
  - R3=0x00F0, R4=0x0F0F; AND dr=5 sr1=3 sr2=4 -> wrData=0x0000, nzp=010.
  - NOT dr=6 sr1=3 -> wrData=0xFF0F, nzp=100.
- Back-to-back dependency: ADD R1<=R1+1 issued 4 times with inValid held high from R1=0x7FFF:
  - first result 0x8000 (nzp=100), final result 0x8003; exactly 4 writes spaced 3 cycles apart.
- Wrap: ADD 0xFFFF+imm 1 -> wrData=0x0000, nzp=010. Counter preset by 65535 retirements -> next retirement gives retired=0.
- Reset mid-operation: assert rst during EXEC and separately during WB -> no writeEN on the reset edge, destination register unchanged, nzp=010, state IDLE the next cycle.
